seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle logic, arithmetic and shift ops, plus iterative shift-add multiply and restoring unsigned divide.
- Adds a valid/ready handshake on both input and output, a high result word, and status flags.
- Sits between the register-file read stage and writeback; the pipeline stalls on in_ready / out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4, power of 2).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode presented
- in_ready  out  1  block can accept an operation
- alu_op  in  4  operation select
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- shamt  in  SHAMT_W  shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  primary result (product low word / quotient)
- result_hi  out  WIDTH  product high word / remainder; 0 for other ops
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- div_by_zero  out  1  DIVU with op_b == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset state:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result, result_hi, zero, overflow and div_by_zero all 0.
  - Reset asserted mid-operation aborts it; no result is ever presented for it.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT (signed); 1000 SLTU (unsigned).
  - 1100 NOR.
  - 1111 SLL (op_b << shamt); 1110 SRL (op_b >> shamt, logical); 1101 SRA (op_b >>> shamt).
  - 1001 MUL (unsigned, 2*WIDTH product); 1010 DIVU.
  - Any other code yields result 0 with 1-cycle latency.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready = 1. An accept (in_valid & in_ready) captures alu_op, op_a, op_b and shamt.
  - From IDLE: MUL, or DIVU with op_b != 0, goes to BUSY with iteration counter = WIDTH. All other ops compute from the captured operands and go to DONE.
  - BUSY: in_ready = 0. One iteration per cycle; counter decrements; leave for DONE when the counter reaches 0.
  - DONE: out_valid = 1; outputs held stable until out_ready = 1. The handshake cycle returns to IDLE. in_ready = 0 in DONE: no accept in the same cycle as output retirement.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - MUL and DIVU: WIDTH + 1 cycles.
  - Back-to-back throughput for single-cycle ops: one op per 2 cycles minimum.
- MUL: shift-add over WIDTH iterations; {result_hi, result} = op_a * op_b, exact, unsigned.
- DIVU: restoring division, one quotient bit per cycle; result = op_a / op_b, result_hi = op_a % op_b.
- DIVU with op_b == 0:
  - No iteration; 1-cycle latency.
  - result = all ones, result_hi = op_a, div_by_zero = 1.
- Flags:
  - zero is computed from result only, for every op, including the undefined-opcode 0.
  - overflow is set on ADD/SUB signed overflow (operand signs match and the result sign differs, with B negated for SUB). It is 0 for all other ops.
  - ADD/SUB wrap modulo 2^WIDTH.
- Input changes: changes on op_a / op_b / alu_op while not accepting are ignored; only the captured copies are used.
- Flag lifetime: all flags update together with result and remain valid only while out_valid = 1.

Test Plan:
- Reset then ADD: WIDTH=32, op_a=0x7FFFFFFF, op_b=1 -> out_valid one cycle after accept; result 0x80000000, overflow=1, zero=0. Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout.
- SUB equal operands: op_a=op_b=0x1234 -> result 0, zero=1, overflow=0. SLT with op_a=0xFFFFFFFF, op_b=1 -> result 1; SLTU with the same operands -> result 0.
- Shifts: op_b=0x80000000, shamt=4 -> SRA gives 0xF8000000; SRL gives 0x08000000; SLL of op_b=1 by shamt=31 gives 0x80000000.
- MUL: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept; result_hi=0xFFFFFFFE, result=0x00000001; in_ready=0 for the whole operation.
- DIVU: op_a=100, op_b=7 -> result 14, result_hi 2 after 33 cycles. op_b=0 -> 1 cycle; result 0xFFFFFFFF, result_hi 100, div_by_zero=1.
- Reset mid-MUL: deassert rst_n 10 cycles after accept -> out_valid stays 0, in_ready=1 after release. Then a new AND 0xF0F0 & 0x0FF0 -> result 0x00F0. Repeat AND/MUL at WIDTH=8 (MUL 0xFF*0xFF -> hi 0xFE, lo 0x01, latency 9).

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes.
// Single-cycle logic/arithmetic/shift ops, iterative shift-add multiply and
// restoring unsigned divide, a high result word and status flags.
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]        sc_res;
  logic [WIDTH-1:0]        sc_hi;
  logic                    sc_ovf;
  logic                    sc_dbz;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic signed [WIDTH-1:0] b_s;
  logic                    iterative;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;

  assign b_s = op_b;

  // Single-cycle result, taken straight from the operands at the accept edge
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sum    = op_a + op_b;
    diff   = op_a - op_b;
    case (alu_op)
      OP_AND:  sc_res = op_a & op_b;
      OP_OR:   sc_res = op_a | op_b;
      OP_NOR:  sc_res = ~(op_a | op_b);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  sc_res = op_b << shamt;
      OP_SRL:  sc_res = op_b >> shamt;
      OP_SRA:  sc_res = b_s >>> shamt;
      OP_DIVU: begin
        // Only reached as a single-cycle op when the divisor is zero
        sc_res = '1;
        sc_hi  = op_a;
        sc_dbz = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  assign iterative = (alu_op == OP_MUL) || ((alu_op == OP_DIVU) && (op_b != '0));

  // One multiply or divide step on the shared {hi_q, lo_q} working register
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (is_div_q) begin
      it_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      is_div_q    <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            in_ready <= 1'b0;
            if (iterative) begin
              is_div_q <= (alu_op == OP_DIVU);
              hi_q     <= '0;
              lo_q     <= (alu_op == OP_DIVU) ? op_a : op_b;
              cnt      <= CNT_W'(WIDTH);
              state    <= BUSY;
            end else begin
              result      <= sc_res;
              result_hi   <= sc_hi;
              zero        <= (sc_res == '0);
              overflow    <= sc_ovf;
              div_by_zero <= sc_dbz;
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        BUSY: begin
          hi_q <= it_hi;
          lo_q <= it_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result      <= it_lo;
            result_hi   <= it_hi;
            zero        <= (it_lo == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b, result, result_hi;
  logic [4:0]  shamt;
  logic        zero, overflow, div_by_zero;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  alu_op8;
  logic [7:0]  op_a8, op_b8, result8, result_hi8;
  logic [2:0]  shamt8;
  logic        zero8, overflow8, div_by_zero8;

  int errors = 0;
  int checks = 0;
  int lat;
  bit busy_ok;
  logic [31:0] r_save;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op8), .op_a(op_a8), .op_b(op_b8), .shamt(shamt8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .result_hi(result_hi8), .zero(zero8), .overflow(overflow8),
    .div_by_zero(div_by_zero8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit, return accept-to-out_valid latency in cycles
  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int l, output bit bz);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; shamt = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; alu_op = 4'b0000;
    l = 0; bz = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      l++;
      if (out_valid) break;
      if (in_ready) bz = 1'b0;
    end
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int l);
    @(negedge clk);
    in_valid8 = 1'b1; alu_op8 = op; op_a8 = a; op_b8 = b; shamt8 = 3'd0;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; op_a8 = 8'h5A; op_b8 = 8'hA5;
    l = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      l++;
      if (out_valid8) break;
    end
  endtask

  task automatic retire32;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic retire8;
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; alu_op = 4'b0; op_a = '0; op_b = '0; shamt = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; alu_op8 = 4'b0; op_a8 = '0; op_b8 = '0; shamt8 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_flags", 64'({zero, overflow, div_by_zero}), 64'd0);
    rst_n = 1'b1;

    // ADD with signed overflow, then hold the result
    run32(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, busy_ok);
    check("add_lat", 64'(lat), 64'd1);
    check("add_res", 64'(result), 64'h8000_0000);
    check("add_ovf", 64'(overflow), 64'd1);
    check("add_zero", 64'(zero), 64'd0);
    check("add_hi", 64'(result_hi), 64'd0);
    r_save = result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res", 64'(result), 64'(r_save));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    retire32();
    @(negedge clk);
    check("add_retired_valid", 64'(out_valid), 64'd0);
    check("add_retired_ready", 64'(in_ready), 64'd1);

    // SUB of equal operands
    run32(4'b0110, 32'h1234, 32'h1234, 5'd0, lat, busy_ok);
    check("sub_res", 64'(result), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_ovf", 64'(overflow), 64'd0);
    retire32();

    // SUB overflow: min - 1
    run32(4'b0110, 32'h8000_0000, 32'h1, 5'd0, lat, busy_ok);
    check("sub_ovf_res", 64'(result), 64'h7FFF_FFFF);
    check("sub_ovf_flag", 64'(overflow), 64'd1);
    retire32();

    // Signed vs unsigned compare
    run32(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, busy_ok);
    check("slt_res", 64'(result), 64'd1);
    retire32();
    run32(4'b1000, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, busy_ok);
    check("sltu_res", 64'(result), 64'd0);
    check("sltu_zero", 64'(zero), 64'd1);
    retire32();

    // Logic ops
    run32(4'b0001, 32'hF000_000F, 32'h0F00_00F0, 5'd0, lat, busy_ok);
    check("or_res", 64'(result), 64'hFF00_00FF);
    retire32();
    run32(4'b1100, 32'hF000_000F, 32'h0F00_00F0, 5'd0, lat, busy_ok);
    check("nor_res", 64'(result), 64'h00FF_FF00);
    check("nor_ovf", 64'(overflow), 64'd0);
    retire32();

    // Shifts
    run32(4'b1101, 32'h0, 32'h8000_0000, 5'd4, lat, busy_ok);
    check("sra_res", 64'(result), 64'hF800_0000);
    retire32();
    run32(4'b1110, 32'h0, 32'h8000_0000, 5'd4, lat, busy_ok);
    check("srl_res", 64'(result), 64'h0800_0000);
    retire32();
    run32(4'b1111, 32'h0, 32'h1, 5'd31, lat, busy_ok);
    check("sll_res", 64'(result), 64'h8000_0000);
    retire32();

    // Undefined opcode
    run32(4'b0011, 32'h5, 32'h5, 5'd0, lat, busy_ok);
    check("undef_lat", 64'(lat), 64'd1);
    check("undef_res", 64'(result), 64'd0);
    check("undef_zero", 64'(zero), 64'd1);
    retire32();

    // MUL full-range
    run32(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, busy_ok);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy_in_ready", 64'(busy_ok), 64'd1);
    check("mul_lo", 64'(result), 64'h1);
    check("mul_hi", 64'(result_hi), 64'hFFFF_FFFE);
    check("mul_flags", 64'({zero, overflow, div_by_zero}), 64'd0);
    retire32();

    run32(4'b1001, 32'h0001_0003, 32'h0002_0005, 5'd0, lat, busy_ok);
    check("mul2_lo", 64'(result), 64'h000B_000F);
    check("mul2_hi", 64'(result_hi), 64'h2);
    retire32();

    // DIVU
    run32(4'b1010, 32'd100, 32'd7, 5'd0, lat, busy_ok);
    check("div_lat", 64'(lat), 64'd33);
    check("div_quo", 64'(result), 64'd14);
    check("div_rem", 64'(result_hi), 64'd2);
    check("div_dbz", 64'(div_by_zero), 64'd0);
    retire32();

    run32(4'b1010, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, lat, busy_ok);
    check("div2_quo", 64'(result), 64'd1);
    check("div2_rem", 64'(result_hi), 64'h7FFF_FFFF);
    retire32();

    run32(4'b1010, 32'd100, 32'd0, 5'd0, lat, busy_ok);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_quo", 64'(result), 64'hFFFF_FFFF);
    check("div0_rem", 64'(result_hi), 64'd100);
    check("div0_dbz", 64'(div_by_zero), 64'd1);
    retire32();

    // Reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'b1001; op_a = 32'h1234; op_b = 32'h5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) busy_ok = 1'b0;
    end
    check("midrst_no_result", 64'(busy_ok), 64'd1);

    run32(4'b0000, 32'hF0F0, 32'h0FF0, 5'd0, lat, busy_ok);
    check("and_res", 64'(result), 64'h00F0);
    check("and_lat", 64'(lat), 64'd1);
    retire32();

    // 8-bit instance
    run8(4'b0000, 8'hF0, 8'h3C, lat);
    check("and8_res", 64'(result8), 64'h30);
    retire8();
    run8(4'b1001, 8'hFF, 8'hFF, lat);
    check("mul8_lat", 64'(lat), 64'd9);
    check("mul8_lo", 64'(result8), 64'h01);
    check("mul8_hi", 64'(result_hi8), 64'hFE);
    retire8();
    run8(4'b1010, 8'd200, 8'd9, lat);
    check("div8_quo", 64'(result8), 64'd22);
    check("div8_rem", 64'(result_hi8), 64'd2);
    retire8();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
